// File: rtl/ceyloniac_memory_arbiter.sv
// Two-requester memory arbiter (core and loader/DMA) sharing one memory port.
// Ties go to whoever did not win last; stalled accesses end in a timeout error.
module ceyloniac_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_ack,
  output logic                  core_err,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_ack,
  output logic                  ldr_err,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    last_ldr_q, last_ldr_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   core_rdata_q, core_rdata_d;
  logic [DATA_WIDTH-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_ldr_q   <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      core_rdata_q <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_ldr_q   <= last_ldr_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      core_rdata_q <= core_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_ldr_d   = last_ldr_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    core_rdata_d = core_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    resp_data    = '0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (core_req && (!ldr_req || last_ldr_q)) begin
          state_d    = BUSY;
          grant_d    = 2'b01;
          last_ldr_d = 1'b0;
          we_d       = core_we;
          addr_d     = core_addr;
          wdata_d    = core_wdata;
        end else if (ldr_req) begin
          state_d    = BUSY;
          grant_d    = 2'b10;
          last_ldr_d = 1'b1;
          we_d       = ldr_we;
          addr_d     = ldr_addr;
          wdata_d    = ldr_wdata;
        end
      end
      BUSY: begin
        // An ack landing in the timeout cycle still counts as a normal completion.
        if (mem_ack) begin
          done      = 1'b1;
          err_d     = 1'b0;
          resp_data = we_q ? '0 : mem_rdata;
        end else if (cnt_q == LAST_CNT) begin
          done  = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done) begin
          state_d = RESP;
          if (grant_q[0]) core_rdata_d = resp_data;
          else            ldr_rdata_d  = resp_data;
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req    = (state_q == BUSY);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign grant      = grant_q;
  assign core_ack   = (state_q == RESP) && grant_q[0];
  assign ldr_ack    = (state_q == RESP) && grant_q[1];
  assign core_err   = core_ack && err_q;
  assign ldr_err    = ldr_ack && err_q;
  assign core_rdata = core_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign core_stall = core_req && !core_ack;

endmodule

// File: tb/tb_ceyloniac_memory_arbiter.sv
// Bench for ceyloniac_memory_arbiter: directed vector table, random transactions
// checked against a transaction-level model, and a reset-during-BUSY sequence.
module tb_ceyloniac_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, core_ack, core_err, core_stall;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          ldr_req, ldr_we, ldr_ack, ldr_err;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata, ldr_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  ceyloniac_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata), .core_stall(core_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_err(ldr_err), .ldr_rdata(ldr_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant(grant)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit model_last_ldr;

  typedef struct {
    bit          c;
    bit          l;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] data;
    logic [1:0]  g;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // New requests only touch a requester that is not already waiting.
  task automatic applyStimulus(input bit new_c, input bit new_l, input bit we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (new_c && !core_req) begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    end
    if (new_l && !ldr_req) begin
      ldr_req   = 1'b1; ldr_we = we;
      ldr_addr  = new_c ? (addr ^ 32'h4) : addr;
      ldr_wdata = new_c ? ~wdata : wdata;
    end
  endtask

  function automatic logic [1:0] predict_grant();
    if (core_req && ldr_req) return model_last_ldr ? 2'b01 : 2'b10;
    if (core_req) return 2'b01;
    if (ldr_req)  return 2'b10;
    return 2'b00;
  endfunction

  task automatic runTxn(input logic [1:0] exp_grant, input int delay, input logic [31:0] mem_data,
                        input bit exp_err, input logic [31:0] exp_rdata, input string tag);
    bit          busy_ok = 1'b1;
    int          k;
    int          exp_lat;
    logic        w_we;
    logic [31:0] w_addr, w_wdata;
    w_we    = exp_grant[1] ? ldr_we    : core_we;
    w_addr  = exp_grant[1] ? ldr_addr  : core_addr;
    w_wdata = exp_grant[1] ? ldr_wdata : core_wdata;
    exp_lat = (delay < TO) ? delay : TO - 1;
    tick();
    checkOutput({tag, ".grant"}, grant, exp_grant);
    for (k = 0; k < TO + 4; k++) begin
      if (mem_req !== 1'b1 || mem_we !== w_we || mem_addr !== w_addr || mem_wdata !== w_wdata ||
          grant !== exp_grant || core_ack !== 1'b0 || ldr_ack !== 1'b0 || core_stall !== core_req)
        busy_ok = 1'b0;
      mem_ack   = (k == delay);
      mem_rdata = (k == delay) ? mem_data : $urandom;
      tick();
      mem_ack = 1'b0;
      if (core_ack || ldr_ack) break;
    end
    checkOutput({tag, ".busy_hold"}, busy_ok, 1'b1);
    checkOutput({tag, ".latency"}, k, exp_lat);
    checkOutput({tag, ".ack"}, {ldr_ack, core_ack}, exp_grant);
    checkOutput({tag, ".err"}, {ldr_err, core_err}, exp_err ? exp_grant : 2'b00);
    checkOutput({tag, ".rdata"}, exp_grant[1] ? ldr_rdata : core_rdata, exp_rdata);
    checkOutput({tag, ".resp_mem_req"}, mem_req, 1'b0);
    checkOutput({tag, ".resp_stall"}, core_stall, exp_grant[0] ? 1'b0 : core_req);
    if (exp_grant[0]) core_req = 1'b0;
    if (exp_grant[1]) ldr_req  = 1'b0;
    if (exp_grant != 2'b00) model_last_ldr = exp_grant[1];
    tick();
    checkOutput({tag, ".idle"}, {grant, core_ack, ldr_ack, core_err, ldr_err}, 6'd0);
    checkOutput({tag, ".rdata_hold"}, exp_grant[1] ? ldr_rdata : core_rdata, exp_rdata);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          new_c, new_l, err;
    logic [1:0]  g;
    int          delay;
    logic [31:0] data, rd;

    vecs[0] = '{1, 1, 0, 32'h10, 32'h0,    1,  32'h11111111, 2'b01, 0, 32'h11111111};
    vecs[1] = '{1, 1, 0, 32'h10, 32'h0,    2,  32'h22222222, 2'b10, 0, 32'h22222222};
    vecs[2] = '{1, 1, 0, 32'h10, 32'h0,    0,  32'h33333333, 2'b01, 0, 32'h33333333};
    vecs[3] = '{1, 1, 0, 32'h10, 32'h0,    1,  32'h44444444, 2'b10, 0, 32'h44444444};
    vecs[4] = '{0, 0, 0, 32'h10, 32'h0,    3,  32'hDEADBEEF, 2'b01, 0, 32'hDEADBEEF};
    vecs[5] = '{0, 1, 1, 32'h40, 32'h1234, 99, 32'hFFFFFFFF, 2'b10, 1, 32'h0};
    vecs[6] = '{1, 0, 0, 32'h80, 32'h0,    15, 32'hCAFEF00D, 2'b01, 0, 32'hCAFEF00D};
    vecs[7] = '{1, 0, 1, 32'h84, 32'h5555, 2,  32'h77777777, 2'b01, 0, 32'h0};
    vecs[8] = '{0, 1, 0, 32'h88, 32'h0,    0,  32'hA5A5A5A5, 2'b10, 0, 32'hA5A5A5A5};
    vecs[9] = '{1, 0, 0, 32'h8C, 32'h0,    16, 32'h99999999, 2'b01, 1, 32'h0};

    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    ldr_req  = 0; ldr_we  = 0; ldr_addr  = '0; ldr_wdata  = '0;
    mem_ack  = 0; mem_rdata = '0;
    model_last_ldr = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset.grant", grant, 2'b00);
    checkOutput("reset.mem", {mem_req, mem_we, mem_addr, mem_wdata}, 66'd0);
    checkOutput("reset.resp", {core_ack, core_err, ldr_ack, ldr_err}, 4'd0);
    checkOutput("reset.rdata", {core_rdata, ldr_rdata}, 64'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].c, vecs[i].l, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      runTxn(vecs[i].g, vecs[i].delay, vecs[i].data, vecs[i].err, vecs[i].rd, $sformatf("vec%0d", i));
    end

    for (int n = 0; n < 40; n++) begin
      new_c = 1'($urandom_range(0, 1));
      new_l = 1'($urandom_range(0, 1));
      if (!core_req && !ldr_req && !new_c && !new_l) new_c = 1'b1;
      applyStimulus(new_c, new_l, 1'($urandom_range(0, 1)), $urandom, $urandom);
      g     = predict_grant();
      delay = $urandom_range(0, TO + 2);
      data  = $urandom;
      err   = (delay >= TO);
      rd    = (err || (g[1] ? ldr_we : core_we)) ? 32'h0 : data;
      runTxn(g, delay, data, err, rd, $sformatf("rnd%0d", n));
    end

    // Reset lands mid-BUSY together with a memory ack; neither may produce a response.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 32'hABCD);
    tick();
    tick();
    tick();
    reset = 1'b1; core_req = 1'b0; ldr_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    reset = 1'b0;
    checkOutput("rst_busy.grant", grant, 2'b00);
    checkOutput("rst_busy.mem", {mem_req, mem_we, mem_addr, mem_wdata}, 66'd0);
    checkOutput("rst_busy.resp", {core_ack, core_err, ldr_ack, ldr_err}, 4'd0);
    checkOutput("rst_busy.rdata", {core_rdata, ldr_rdata}, 64'd0);
    tick();
    checkOutput("spurious.ack1", {core_ack, ldr_ack, mem_req, grant}, 5'd0);
    tick();
    checkOutput("spurious.ack2", {core_ack, ldr_ack, mem_req, grant}, 5'd0);
    mem_ack = 1'b0;
    model_last_ldr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    runTxn(2'b01, 4, 32'h0BADF00D, 1'b0, 32'h0BADF00D, "post_reset_tie");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
